// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: hazard stalls/flushes, PC-write enable and a debug halt/step FSM.
// Define PIPE_CTRL_PERF_EN to build the saturating fetch-stall counter driven on stall_count.
module pipe_ctrl #(
    parameter int REGADDR_W    = 3,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REGADDR_W-1:0] id_rs,
    input  logic [REGADDR_W-1:0] id_rt,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    input  logic [REGADDR_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_reg_write,
    input  logic                 ex_branch_taken,
    input  logic                 mem_busy,
    input  logic                 halt_req,
    input  logic                 step_req,
    input  logic                 resume_req,
    output logic                 pc_write,
    output logic                 if_id_stall,
    output logic                 if_id_flush,
    output logic                 id_ex_stall,
    output logic                 id_ex_flush,
    output logic                 ex_mem_stall,
    output logic                 mem_wb_flush,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } state_e;

    localparam int               DRN_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES);

    state_e           state_q, state_d;
    logic [DRN_W-1:0] drain_q, drain_d;

    logic rs_hit;
    logic rt_hit;
    logic luh;

    // r0 is deliberately not exempt: a load into r0 still blocks its consumer.
    assign rs_hit = id_use_rs && (id_rs == ex_rd);
    assign rt_hit = id_use_rt && (id_rt == ex_rd);
    assign luh    = ex_mem_read && ex_reg_write && (rs_hit || rt_hit);

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                // The drain only advances on cycles where the pipe actually moves.
                if (!mem_busy) begin
                    if (drain_q == DRN_W'(1)) begin
                        state_d = ST_HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - DRN_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                if (resume_req) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (pc_write) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            default: begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        endcase
    end

    // NOTE: every output is given a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        pc_write     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        halted       = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_HALTED: begin
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    halted      = 1'b1;
                end
                default: begin
                    if (mem_busy) begin
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                        mem_wb_flush = 1'b1;
                    end else if (ex_branch_taken) begin
                        pc_write    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (luh) begin
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_write = (state_q != ST_DRAIN);
                    end
                    // Fetch is blocked while draining: IF/ID only ever receives bubbles.
                    if (state_q == ST_DRAIN) begin
                        if_id_flush = 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             fetch_stalled;

    assign fetch_stalled = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !pc_write;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (fetch_stalled && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: hazards, branch/busy priority, halt/step/resume, async reset.
module tb_pipe_ctrl;

    localparam int REGADDR_W = 3;
    localparam int CNT_W     = 16;

    typedef struct packed {
        logic pc_write;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
        logic halted;
    } ctl_t;

    logic                 clk;
    logic                 reset;
    logic [REGADDR_W-1:0] id_rs, id_rt, ex_rd;
    logic                 id_use_rs, id_use_rt;
    logic                 ex_mem_read, ex_reg_write, ex_branch_taken;
    logic                 mem_busy, halt_req, step_req, resume_req;
    logic                 pc_write, if_id_stall, if_id_flush, id_ex_stall;
    logic                 id_ex_flush, ex_mem_stall, mem_wb_flush, halted;
    logic [CNT_W-1:0]     stall_count;

    int tests = 0;
    int fails = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    ctl_t             exp_q[$];
    logic [CNT_W-1:0] cnt_q[$];
    string            tag_q[$];

    pipe_ctrl #(.REGADDR_W(REGADDR_W), .DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
        .pc_write(pc_write), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_flush(mem_wb_flush), .halted(halted), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected control vectors, field order: pc, ifs, iff, ies, ief, ems, mwf, halted.
    function automatic ctl_t e_zero();   return 8'b0000_0000; endfunction
    function automatic ctl_t e_norm();   return 8'b1000_0000; endfunction
    function automatic ctl_t e_luh();    return 8'b0100_1000; endfunction
    function automatic ctl_t e_branch(); return 8'b1010_1000; endfunction
    function automatic ctl_t e_busy();   return 8'b0101_0110; endfunction
    function automatic ctl_t e_drain();  return 8'b0010_0000; endfunction
    function automatic ctl_t e_drbusy(); return 8'b0111_0110; endfunction
    function automatic ctl_t e_halted(); return 8'b0100_1001; endfunction

    function automatic logic [CNT_W-1:0] exp_stall();
`ifdef PIPE_CTRL_PERF_EN
        return exp_cnt;
`else
        return '0;
`endif
    endfunction

    task automatic expect_out(input ctl_t e, input string tag);
        exp_q.push_back(e);
        cnt_q.push_back(exp_stall());
        tag_q.push_back(tag);
    endtask

    task automatic score();
        ctl_t             e, o;
        logic [CNT_W-1:0] ec;
        string            t;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: observed=empty required=entry");
            return;
        end
        e  = exp_q.pop_front();
        ec = cnt_q.pop_front();
        t  = tag_q.pop_front();
        o  = {pc_write, if_id_stall, if_id_flush, id_ex_stall,
              id_ex_flush, ex_mem_stall, mem_wb_flush, halted};
        assert (o === e) else begin
            fails++;
            $error("FAIL %s ctl: observed=%b expected=%b", t, o, e);
        end
        tests++;
        assert (stall_count === ec) else begin
            fails++;
            $error("FAIL %s stall_count: observed=%0d expected=%0d", t, stall_count, ec);
        end
    endtask

    // One clock cycle: inputs already driven, outputs sampled on the falling edge.
    task automatic cyc(input ctl_t e, input bit inc, input string tag);
        expect_out(e, tag);
        @(negedge clk);
        score();
        if (inc && exp_cnt != {CNT_W{1'b1}}) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_branch_taken = 1'b0;
        mem_busy = 1'b0; halt_req = 1'b0; step_req = 1'b0; resume_req = 1'b0;
    endtask

    task automatic load_use(input logic [REGADDR_W-1:0] rd, input bit via_rt);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
        id_use_rs = !via_rt; id_use_rt = via_rt;
        id_rs = rd; id_rt = rd;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #2;
        expect_out(e_zero(), "reset_async");
        score();
        @(negedge clk);
        expect_out(e_zero(), "reset_hold");
        score();
        reset = 1'b0;
        @(posedge clk);
        #1;

        cyc(e_norm(), 0, "run_idle");
        load_use(3'd3, 0);
        cyc(e_luh(), 1, "luh_rs");
        ex_mem_read = 1'b0;
        cyc(e_norm(), 0, "luh_released");
        load_use(3'd0, 1);
        cyc(e_luh(), 1, "luh_rt_r0");
        ex_reg_write = 1'b0;
        cyc(e_norm(), 0, "load_no_regwrite");
        load_use(3'd5, 0);
        id_use_rs = 1'b0;
        cyc(e_norm(), 0, "luh_src_unused");

        load_use(3'd2, 0);
        ex_branch_taken = 1'b1;
        cyc(e_branch(), 0, "branch_over_luh");
        idle_inputs();
        ex_branch_taken = 1'b1;
        mem_busy = 1'b1;
        cyc(e_busy(), 1, "busy_branch_1");
        cyc(e_busy(), 1, "busy_branch_2");
        cyc(e_busy(), 1, "busy_branch_3");
        mem_busy = 1'b0;
        cyc(e_branch(), 0, "branch_after_busy");
        ex_branch_taken = 1'b0;
        cyc(e_norm(), 0, "run_after_branch");

        // Halt: request cycle, 4 drain steps with one busy hold, halted on the 7th cycle.
        halt_req = 1'b1;
        cyc(e_norm(), 0, "halt_req_run");
        halt_req = 1'b0;
        cyc(e_drain(), 0, "drain_1");
        mem_busy = 1'b1;
        cyc(e_drbusy(), 0, "drain_busy");
        mem_busy = 1'b0;
        ex_branch_taken = 1'b1;
        cyc(e_branch(), 0, "drain_branch");
        ex_branch_taken = 1'b0;
        cyc(e_drain(), 0, "drain_3");
        cyc(e_drain(), 0, "drain_4");
        halt_req = 1'b1;
        mem_busy = 1'b1;
        cyc(e_halted(), 0, "halted_busy_ignored");
        mem_busy = 1'b0;
        cyc(e_halted(), 0, "halted_hold");

        // Single step with the fetch blocked once by a load-use hazard.
        halt_req = 1'b0;
        step_req = 1'b1;
        cyc(e_halted(), 0, "step_req");
        step_req = 1'b0;
        load_use(3'd7, 1);
        cyc(e_luh(), 1, "step_blocked");
        idle_inputs();
        cyc(e_norm(), 0, "step_fetch");
        cyc(e_drain(), 0, "step_drain_1");
        cyc(e_drain(), 0, "step_drain_2");
        cyc(e_drain(), 0, "step_drain_3");
        cyc(e_drain(), 0, "step_drain_4");
        cyc(e_halted(), 0, "step_halted");

        step_req = 1'b1;
        resume_req = 1'b1;
        cyc(e_halted(), 0, "step_and_resume");
        idle_inputs();
        cyc(e_norm(), 0, "resumed_run");

        // Asynchronous reset landing in the middle of a drain.
        halt_req = 1'b1;
        cyc(e_norm(), 0, "halt_req_2");
        halt_req = 1'b0;
        cyc(e_drain(), 0, "drain_pre_reset");
        #2;
        reset = 1'b1;
        exp_cnt = '0;
        #1;
        expect_out(e_zero(), "reset_mid_drain");
        score();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc(e_norm(), 0, "run_after_reset");
        load_use(3'd4, 0);
        cyc(e_luh(), 1, "luh_after_reset");
        idle_inputs();
        cyc(e_norm(), 0, "count_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
